// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped front end for the buart serializer.
// Buffers TX bytes and paces buart wr pulses against busy. Drains buart
// valid bytes into an RX FIFO with a one-cycle rd acknowledge. Exposes
// status, sticky error flags and an RX-not-empty interrupt.
// Ports:
//   clk, resetq           clock, async active-low reset
//   ip_sel/ip_addr/ip_wr/ip_rd/ip_wdata, op_rdata/op_valid  processor bus
//   op_irq                rx_irq_en & ~rx_empty
//   op_uart_wr/op_uart_tx_data/op_uart_rd, ip_uart_rx_data/busy/valid  buart side
module uart_mmio_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        ip_sel,
  input  logic [1:0]  ip_addr,
  input  logic        ip_wr,
  input  logic        ip_rd,
  input  logic [31:0] ip_wdata,
  output logic [31:0] op_rdata,
  output logic        op_valid,
  output logic        op_irq,
  output logic        op_uart_wr,
  output logic [7:0]  op_uart_tx_data,
  output logic        op_uart_rd,
  input  logic [7:0]  ip_uart_rx_data,
  input  logic        ip_uart_busy,
  input  logic        ip_uart_valid
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_LAUNCH, TX_GUARD, TX_WAIT} tx_state_e;
  typedef enum logic {RX_IDLE, RX_HOLD} rx_state_e;

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wptr_q, tx_rptr_q;
  logic [RAW-1:0] rx_wptr_q, rx_rptr_q;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic           tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, irq_en_q, irq_en_d;
  logic           uart_wr_q, uart_wr_d;
  logic [7:0]     tx_data_q, tx_data_d;

  logic tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic wr_en, rd_en, ctrl_wr;
  logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop;

  logic unused_wdata;
  assign unused_wdata = ^ip_wdata[31:8];

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
  assign tx_idle  = tx_empty & (tx_state_q == TX_IDLE);

  assign wr_en       = ip_sel & ip_wr;
  assign rd_en       = ip_sel & ip_rd;
  assign ctrl_wr     = wr_en & (ip_addr == 2'd2);
  assign tx_push_req = wr_en & (ip_addr == 2'd0);
  // Full/empty come from pre-edge state, so a full FIFO drops a push even
  // when the same edge also pops.
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = (tx_state_q == TX_IDLE) & ~tx_empty;
  assign op_uart_rd  = (rx_state_q == RX_IDLE) & ip_uart_valid;
  assign rx_push     = op_uart_rd & ~rx_full;
  assign rx_pop      = rd_en & (ip_addr == 2'd0) & ~rx_empty;

  assign op_valid        = rd_en;
  assign op_irq          = irq_en_q & ~rx_empty;
  assign op_uart_wr      = uart_wr_q;
  assign op_uart_tx_data = tx_data_q;

  // FIFO storage carries no reset; pointers/counts define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= ip_wdata[7:0];
    if (rx_push) rx_mem[rx_wptr_q] <= ip_uart_rx_data;
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TCW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TCW'(1);
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + RCW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RCW'(1);
    // Sticky flags: a set in the same cycle as a clear wins.
    tx_ovf_d = (tx_ovf_q & ~(ctrl_wr & ip_wdata[0])) | (tx_push_req & tx_full);
    rx_ovr_d = (rx_ovr_q & ~(ctrl_wr & ip_wdata[1])) | (op_uart_rd & rx_full);
    irq_en_d = ctrl_wr ? ip_wdata[2] : irq_en_q;
  end

  // TX sequencer: wr is registered so it is high exactly during LAUNCH.
  always_comb begin
    tx_state_d = tx_state_q;
    uart_wr_d  = 1'b0;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      TX_IDLE: if (!tx_empty) begin
        tx_state_d = TX_LAUNCH;
        uart_wr_d  = 1'b1;
        tx_data_d  = tx_mem[tx_rptr_q];
      end
      TX_LAUNCH: tx_state_d = TX_GUARD;
      // busy may lag wr by a cycle, so it is not trusted until WAIT.
      TX_GUARD:  tx_state_d = TX_WAIT;
      TX_WAIT:   if (!ip_uart_busy) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  // RX: HOLD masks valid for the cycle after rd while buart clears it.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (ip_uart_valid) rx_state_d = RX_HOLD;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      uart_wr_q  <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      if (tx_push) tx_wptr_q <= tx_wptr_q + TAW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + TAW'(1);
      if (rx_push) rx_wptr_q <= rx_wptr_q + RAW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + RAW'(1);
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovr_q   <= rx_ovr_d;
      irq_en_q   <= irq_en_d;
      uart_wr_q  <= uart_wr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    op_rdata = 32'h0;
    if (ip_sel) begin
      case (ip_addr)
        2'd0: op_rdata = rx_empty ? 32'h0000_0100 : {24'h0, rx_mem[rx_rptr_q]};
        2'd1: op_rdata = {8'(rx_cnt_q), 8'(tx_cnt_q), 9'h0, tx_idle, rx_ovr_q,
                          tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
        2'd2: op_rdata = {29'h0, irq_en_q, 2'b00};
        default: op_rdata = 32'h0;
      endcase
    end
  end
endmodule
